// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses fault).
package lsu_pkg;

    localparam int LSU_LANES  = 4;
    localparam int LSU_OFF_W  = 2;
    localparam int LSU_DATA_W = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD_WAIT,
        S_LOAD_DONE,
        S_FAULT
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane select with sign/zero extension.
// Optional feature macro: none (see load_store_unit).
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [LSU_DATA_W-1:0] word_i,
    input  logic [LSU_OFF_W-1:0]  offset_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    output logic [LSU_DATA_W-1:0] data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    // pick the addressed lane, then extend to 32 bits
    always_comb begin
        byte_w = word_i[8*offset_i +: 8];
        half_w = offset_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = word_i;
        unique case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & byte_w[7]}}, byte_w};
            SZ_HALF: data_o = {{16{~unsigned_i & half_w[15]}}, half_w};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-wide byte-enabled RAM port.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses fault).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clk_en,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_is_store,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [4:0]            i_req_rd,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [4:0]            o_rsp_rd,
    output logic                  o_rsp_fault,
    output logic [ADDR_WIDTH-1:0] o_ram_read_addr,
    input  logic [DATA_WIDTH-1:0] i_ram_read_data,
    output logic                  o_ram_write_en,
    output logic [3:0]            o_ram_byte_en,
    output logic [ADDR_WIDTH-1:0] o_ram_write_addr,
    output logic [DATA_WIDTH-1:0] o_ram_write_data
);

    lsu_state_t state_q, state_d;

    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [LSU_OFF_W-1:0]  offset_q;
    logic [4:0]            rd_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [ADDR_WIDTH-1:0] raddr_q;

    logic [1:0]            size;
    logic [LSU_OFF_W-1:0]  offset;
    logic                  misaligned;
    logic                  req_fault;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] load_data;

    assign accept   = i_clk_en && i_req_valid && (state_q == S_IDLE);
    assign word_idx = {2'b00, i_req_addr[ADDR_WIDTH-1:2]};

    // decode width, effective lane offset, fault and store lanes
    always_comb begin
        size       = i_req_funct3[1:0];
        offset     = '0;
        be_d       = 4'b1111;
        wdata_d    = i_req_wdata;
        misaligned = 1'b0;
        unique case (size)
            SZ_BYTE: begin
                offset  = i_req_addr[1:0];
                be_d    = 4'b0001 << offset;
                wdata_d = {4{i_req_wdata[7:0]}};
            end
            SZ_HALF: begin
                offset     = {i_req_addr[1], 1'b0};
                misaligned = i_req_addr[0];
                be_d       = 4'b0011 << offset;
                wdata_d    = {2{i_req_wdata[15:0]}};
            end
            default: begin
                misaligned = (i_req_addr[1:0] != 2'b00);
            end
        endcase
        req_fault = (size == SZ_BAD)
                  || (i_req_is_store && i_req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        req_fault = req_fault || misaligned;
`endif
    end

    // next-state sequencing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (req_fault)          state_d = S_FAULT;
                    else if (i_req_is_store) state_d = S_STORE;
                    else                    state_d = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: state_d = S_LOAD_DONE;
            default:     state_d = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         state_q <= S_IDLE;
        else if (i_clk_en) state_q <= state_d;
    end

    // capture the request; read index only moves on a good load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            size_q     <= '0;
            unsigned_q <= 1'b0;
            offset_q   <= '0;
            rd_q       <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
        end else if (accept) begin
            size_q     <= size;
            unsigned_q <= i_req_funct3[2];
            offset_q   <= offset;
            rd_q       <= i_req_rd;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            waddr_q    <= word_idx;
            if (!req_fault && !i_req_is_store) raddr_q <= word_idx;
        end
    end

    lsu_load_align u_align (
        .word_i     (i_ram_read_data),
        .offset_i   (offset_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (load_data)
    );

    // outputs purely from state and captured registers
    always_comb begin
        o_req_ready      = (state_q == S_IDLE);
        o_rsp_valid      = (state_q == S_STORE) || (state_q == S_LOAD_DONE)
                        || (state_q == S_FAULT);
        o_rsp_fault      = (state_q == S_FAULT);
        o_rsp_rd         = o_rsp_valid ? rd_q : 5'd0;
        o_rsp_data       = (state_q == S_LOAD_DONE) ? load_data : '0;
        o_ram_read_addr  = raddr_q;
        o_ram_write_en   = (state_q == S_STORE);
        o_ram_byte_en    = o_ram_write_en ? be_q : 4'b0000;
        o_ram_write_addr = o_ram_write_en ? waddr_q : '0;
        o_ram_write_data = o_ram_write_en ? wdata_q : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-level memory model.
// Honours LSU_MISALIGN_TRAP_EN when computing expected faults.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_clk_en = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_is_store = 1'b0;
    logic [2:0]  i_req_funct3 = 3'b0;
    logic [31:0] i_req_addr = 32'b0;
    logic [31:0] i_req_wdata = 32'b0;
    logic [4:0]  i_req_rd = 5'b0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic [4:0]  o_rsp_rd;
    logic        o_rsp_fault;
    logic [31:0] o_ram_read_addr;
    logic [31:0] i_ram_read_data = 32'b0;
    logic        o_ram_write_en;
    logic [3:0]  o_ram_byte_en;
    logic [31:0] o_ram_write_addr;
    logic [31:0] o_ram_write_data;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [64];
    logic [7:0]  ref_mem [256];

    load_store_unit dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_clk_en         (i_clk_en),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_is_store   (i_req_is_store),
        .i_req_funct3     (i_req_funct3),
        .i_req_addr       (i_req_addr),
        .i_req_wdata      (i_req_wdata),
        .i_req_rd         (i_req_rd),
        .o_rsp_valid      (o_rsp_valid),
        .o_rsp_data       (o_rsp_data),
        .o_rsp_rd         (o_rsp_rd),
        .o_rsp_fault      (o_rsp_fault),
        .o_ram_read_addr  (o_ram_read_addr),
        .i_ram_read_data  (i_ram_read_data),
        .o_ram_write_en   (o_ram_write_en),
        .o_ram_byte_en    (o_ram_byte_en),
        .o_ram_write_addr (o_ram_write_addr),
        .o_ram_write_data (o_ram_write_data)
    );

    always #5 i_clk = ~i_clk;

    // local_ram stand-in: registered read every edge, gated byte writes
    always @(posedge i_clk) begin
        i_ram_read_data <= ram[o_ram_read_addr[5:0]];
        if (o_ram_write_en && i_clk_en) begin
            for (int k = 0; k < 4; k++)
                if (o_ram_byte_en[k])
                    ram[o_ram_write_addr[5:0]][8*k +: 8] <= o_ram_write_data[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[4*idx+3], ref_mem[4*idx+2],
                ref_mem[4*idx+1], ref_mem[4*idx]};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // one request through the unit, checked against the byte model
    task automatic run_op(input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd);
        int          n;
        int          ea;
        bit          flt;
        logic [31:0] exp;
        logic [63:0] mask;
        logic [3:0]  be;
        n   = 1 << f3[1:0];
        flt = (f3[1:0] == 2'b11) || (st && f3[2]);
        if (!flt && TRAP && (int'(a) % n) != 0) flt = 1'b1;
        ea  = flt ? int'(a) : int'(a) - (int'(a) % n);
        chk("ready_before", {31'b0, o_req_ready}, 32'd1);
        i_req_valid    = 1'b1;
        i_req_is_store = st;
        i_req_funct3   = f3;
        i_req_addr     = a;
        i_req_wdata    = wd;
        i_req_rd       = rd;
        step();
        i_req_valid = 1'b0;
        i_req_wdata = ~wd;
        chk("t1_rsp_valid", {31'b0, o_rsp_valid}, {31'b0, flt | st});
        chk("t1_fault", {31'b0, o_rsp_fault}, {31'b0, flt});
        chk("t1_write_en", {31'b0, o_ram_write_en}, {31'b0, st & ~flt});
        if (flt) begin
            chk("fault_data", o_rsp_data, 32'd0);
        end else if (st) begin
            be = '0;
            for (int i = 0; i < n; i++) be[(ea % 4) + i] = 1'b1;
            chk("store_byte_en", {28'b0, o_ram_byte_en}, {28'b0, be});
            chk("store_addr", o_ram_write_addr, 32'(ea / 4));
            chk("store_rd", {27'b0, o_rsp_rd}, {27'b0, rd});
            for (int i = 0; i < n; i++) ref_mem[ea + i] = wd[8*i +: 8];
        end
        step();
        if (!flt && !st) begin
            exp = '0;
            for (int i = 0; i < n; i++) exp = exp | (32'(ref_mem[ea + i]) << (8 * i));
            mask = (64'd1 << (8 * n)) - 64'd1;
            if (!f3[2] && exp[8*n-1]) exp = exp | ~mask[31:0];
            chk("load_valid", {31'b0, o_rsp_valid}, 32'd1);
            chk("load_fault", {31'b0, o_rsp_fault}, 32'd0);
            chk("load_data", o_rsp_data, exp);
            chk("load_rd", {27'b0, o_rsp_rd}, {27'b0, rd});
            step();
        end else if (st && !flt) begin
            chk("ram_word", ram[ea / 4], ref_word(ea / 4));
        end
        chk("idle_after", {31'b0, o_rsp_valid}, 32'd0);
    endtask

    logic [2:0]  f3_tab [7];
    logic [31:0] held;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101; f3_tab[5] = 3'b011;
        f3_tab[6] = 3'b110;

        #12;
        chk("rst_ready", {31'b0, o_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_write_en", {31'b0, o_ram_write_en}, 32'd0);
        chk("rst_read_addr", o_ram_read_addr, 32'd0);
        chk("rst_rsp_data", o_rsp_data, 32'd0);
        i_rst = 1'b0;
        step();

        run_op(1'b0, 3'b010, 32'h0, 32'h0, 5'd1);
        run_op(1'b1, 3'b000, 32'h6, 32'h1234_56AB, 5'd2);
        chk("sb_word", ram[1], 32'h00AB_0000);
        run_op(1'b1, 3'b010, 32'h0, 32'hCAFE_BABE, 5'd3);
        run_op(1'b1, 3'b010, 32'h4, 32'h80FF_7F01, 5'd4);
        run_op(1'b0, 3'b000, 32'h5, 32'h0, 5'd5);
        run_op(1'b0, 3'b100, 32'h6, 32'h0, 5'd6);
        run_op(1'b0, 3'b000, 32'h7, 32'h0, 5'd7);
        run_op(1'b0, 3'b001, 32'h6, 32'h0, 5'd8);
        run_op(1'b0, 3'b010, 32'h4, 32'h0, 5'd9);
        run_op(1'b0, 3'b010, 32'h2, 32'h0, 5'd10);
        run_op(1'b0, 3'b011, 32'h0, 32'h0, 5'd11);
        run_op(1'b1, 3'b100, 32'h8, 32'h1111_1111, 5'd12);
        run_op(1'b1, 3'b001, 32'h3, 32'h0000_BEEF, 5'd13);

        // stall in LOAD_DONE with a request waiting
        i_req_valid    = 1'b1;
        i_req_is_store = 1'b0;
        i_req_funct3   = 3'b000;
        i_req_addr     = 32'h7;
        i_req_rd       = 5'd14;
        step();
        step();
        i_clk_en = 1'b0;
        held = o_rsp_data;
        chk("stall_data0", held, 32'hFFFF_FF80);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_valid", {31'b0, o_rsp_valid}, 32'd1);
            chk("stall_data", o_rsp_data, 32'hFFFF_FF80);
            chk("stall_ready", {31'b0, o_req_ready}, 32'd0);
        end
        i_clk_en = 1'b1;
        step();
        chk("stall_release_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("stall_release_ready", {31'b0, o_req_ready}, 32'd1);
        i_req_valid = 1'b0;
        step();

        // reset while the store strobe is up
        held = ref_word(4);
        i_req_valid    = 1'b1;
        i_req_is_store = 1'b1;
        i_req_funct3   = 3'b010;
        i_req_addr     = 32'h10;
        i_req_wdata    = 32'h5555_5555;
        step();
        i_req_valid = 1'b0;
        chk("pre_rst_write_en", {31'b0, o_ram_write_en}, 32'd1);
        i_rst = 1'b1;
        #1;
        chk("rst_mid_write_en", {31'b0, o_ram_write_en}, 32'd0);
        chk("rst_mid_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        step();
        i_rst = 1'b0;
        chk("rst_mid_ram", ram[4], held);
        chk("rst_mid_ready", {31'b0, o_req_ready}, 32'd1);
        step();

        for (int r = 0; r < 300; r++) begin
            run_op(1'($urandom_range(0, 1)),
                   f3_tab[$urandom_range(0, 6)],
                   32'($urandom_range(0, 255)),
                   $urandom,
                   5'($urandom_range(0, 31)));
        end
        for (int w = 0; w < 64; w++) chk("final_ram", ram[w], ref_word(w));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
